// File: rtl/pipeline_stall_ctrl.sv
// Central stall sequencer: merges IF/ID hazards, counts down multi-cycle EX ops
// and supervises MEM bus waits with a timeout, producing the pipeline hold vector.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall_req,
    input  logic             id_stall_req,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             flush,
    output logic [5:0]       control,
    output logic             ex_mc_done,
    output logic             mem_timeout,
    output logic [3:0]       state_dbg
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_t;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } mem_state_t;

    ex_state_t        ex_state, ex_next;
    mem_state_t       mem_state, mem_next;
    logic [CNT_W-1:0] ex_cnt, ex_cnt_next;
    logic [TW-1:0]    mem_cnt, mem_cnt_next;
    logic             ex_stall, mem_stall;
    logic [5:0]       mask;

    // ex_mc_done and mem_timeout are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_state    <= EX_IDLE;
            mem_state   <= MEM_IDLE;
            ex_cnt      <= '0;
            mem_cnt     <= '0;
            ex_mc_done  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            ex_state    <= ex_next;
            mem_state   <= mem_next;
            ex_cnt      <= ex_cnt_next;
            mem_cnt     <= mem_cnt_next;
            ex_mc_done  <= (ex_next == EX_DONE);
            mem_timeout <= (mem_next == MEM_ERR);
        end
    end

    always_comb begin
        ex_next     = ex_state;
        ex_cnt_next = ex_cnt;
        if (flush) begin
            ex_next     = EX_IDLE;
            ex_cnt_next = '0;
        end else begin
            case (ex_state)
                EX_BUSY: begin
                    if (ex_cnt == CNT_W'(1)) begin
                        ex_next     = EX_DONE;
                        ex_cnt_next = '0;
                    end else begin
                        ex_cnt_next = ex_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    // The start cycle is itself the first stalled cycle
                    if (ex_mc_start) begin
                        if (ex_mc_cycles <= CNT_W'(1)) begin
                            ex_next     = EX_DONE;
                            ex_cnt_next = '0;
                        end else begin
                            ex_next     = EX_BUSY;
                            ex_cnt_next = ex_mc_cycles - CNT_W'(1);
                        end
                    end else begin
                        ex_next = EX_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_next     = mem_state;
        mem_cnt_next = mem_cnt;
        if (flush) begin
            mem_next     = MEM_IDLE;
            mem_cnt_next = '0;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        mem_next     = MEM_WAIT;
                        mem_cnt_next = TW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack || !mem_req) begin
                        mem_next     = MEM_IDLE;
                        mem_cnt_next = '0;
                    end else if (mem_cnt == TW'(MEM_TIMEOUT - 1)) begin
                        mem_next = MEM_ERR;
                    end else begin
                        mem_cnt_next = mem_cnt + TW'(1);
                    end
                end
                MEM_ERR: begin
                    mem_next = MEM_ERR;
                end
                default: begin
                    mem_next     = MEM_IDLE;
                    mem_cnt_next = '0;
                end
            endcase
        end
    end

    // The highest stalled stage k holds itself and everything upstream
    always_comb begin
        ex_stall  = (ex_state == EX_BUSY) ||
                    (ex_mc_start && (ex_mc_cycles != '0));
        mem_stall = (mem_state == MEM_ERR) || (mem_req && !mem_ack);
        if (mem_stall)
            mask = 6'b011111;
        else if (ex_stall)
            mask = 6'b001111;
        else if (id_stall_req)
            mask = 6'b000111;
        else if (if_stall_req)
            mask = 6'b000011;
        else
            mask = 6'b000000;
        control   = (rst || flush) ? 6'b000000 : mask;
        state_dbg = {ex_state, mem_state};
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random
// traffic, checked against a cycle-timestamp reference model.
module tb_pipeline_stall_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_stall_req, id_stall_req, ex_mc_start;
    logic [CNT_W-1:0] ex_mc_cycles;
    logic             mem_req, mem_ack, flush;
    logic [5:0]       control;
    logic             ex_mc_done, mem_timeout;
    logic [3:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: EX stalls while cyc < ex_stall_end and reports done at ex_done_at;
    // MEM counts consecutive un-acked wait cycles until the error latches.
    int ex_stall_end = -1;
    int ex_done_at   = -1;
    int mem_wait_len = 0;
    bit mem_err      = 1'b0;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_stall_req (if_stall_req),
        .id_stall_req (id_stall_req),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .flush        (flush),
        .control      (control),
        .ex_mc_done   (ex_mc_done),
        .mem_timeout  (mem_timeout),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ex_stall_end = -1;
        ex_done_at   = -1;
        mem_wait_len = 0;
        mem_err      = 1'b0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    // planCtrl >= 0 additionally pins control to a hand-derived constant.
    task automatic applyStimulus(input logic i_if, input logic i_id, input logic i_start,
                                 input int n, input logic i_req, input logic i_ack,
                                 input logic i_flush, input int planCtrl);
        logic [5:0] exp_ctrl;
        logic       exp_done, exp_to;
        bit         ex_st, mem_st;
        int         k;
        if_stall_req = i_if;
        id_stall_req = i_id;
        ex_mc_start  = i_start;
        ex_mc_cycles = CNT_W'(n);
        mem_req      = i_req;
        mem_ack      = i_ack;
        flush        = i_flush;
        @(negedge clk);
        exp_done = (cyc == ex_done_at);
        exp_to   = mem_err;
        if (i_flush) begin
            exp_ctrl = 6'b000000;
            model_reset();
        end else begin
            if (i_start && cyc >= ex_stall_end) begin
                ex_stall_end = cyc + n;
                ex_done_at   = cyc + ((n == 0) ? 1 : n);
            end
            ex_st = (cyc < ex_stall_end);
            if (mem_err) begin
                mem_st = 1'b1;
            end else if (i_req && !i_ack) begin
                mem_st = 1'b1;
                mem_wait_len++;
                if (mem_wait_len == MEM_TIMEOUT) mem_err = 1'b1;
            end else begin
                mem_st       = 1'b0;
                mem_wait_len = 0;
            end
            k = mem_st ? 4 : ex_st ? 3 : i_id ? 2 : i_if ? 1 : 0;
            exp_ctrl = (k == 0) ? 6'b000000 : 6'((1 << (k + 1)) - 1);
        end
        checkOutput("control", control, exp_ctrl);
        checkOutput("ex_mc_done", {5'b0, ex_mc_done}, {5'b0, exp_done});
        checkOutput("mem_timeout", {5'b0, mem_timeout}, {5'b0, exp_to});
        if (planCtrl >= 0) checkOutput("control_plan", control, 6'(planCtrl));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input int planCtrl);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, planCtrl);
    endtask

    initial begin
        logic r_req;
        int   ack_pct;
        rst = 1'b1;
        if_stall_req = 0; id_stall_req = 0; ex_mc_start = 0; ex_mc_cycles = '0;
        mem_req = 0; mem_ack = 0; flush = 0;
        #1;
        checkOutput("reset_control", control, 6'b000000);
        checkOutput("reset_done", {5'b0, ex_mc_done}, 6'b000000);
        checkOutput("reset_timeout", {5'b0, mem_timeout}, 6'b000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2, 0);

        $display("[TB] IF+ID together");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 6'b000111);
        idle(1, 0);

        $display("[TB] EX N=4, N=0, N=1");
        applyStimulus(0, 0, 1, 4, 0, 0, 0, 6'b001111);
        idle(3, 6'b001111);
        idle(1, 0);
        idle(1, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        idle(2, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 6'b001111);
        idle(2, 0);

        $display("[TB] MEM ack after 3 cycles");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 6'b011111);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
        idle(1, 0);

        $display("[TB] MEM timeout and flush");
        for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 6'b011111);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 6'b011111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 6'b011111);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        idle(2, 0);

        $display("[TB] EX N=6 overlapping MEM wait");
        applyStimulus(0, 0, 1, 6, 1, 0, 0, 6'b011111);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 6'b011111);
        applyStimulus(0, 1, 1, 3, 0, 0, 0, 6'b001111);
        idle(3, 6'b001111);
        idle(2, 0);

        $display("[TB] async reset mid EX_BUSY");
        applyStimulus(0, 0, 1, 8, 0, 0, 0, 6'b001111);
        idle(2, 6'b001111);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_control", control, 6'b000000);
        checkOutput("async_rst_done", {5'b0, ex_mc_done}, 6'b000000);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle(8, 0);

        $display("[TB] random traffic");
        r_req = 1'b0;
        for (int phase = 0; phase < 2; phase++) begin
            ack_pct = (phase == 0) ? 25 : 2;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 9) < 2) r_req = ~r_req;
                applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                              $urandom_range(0, 6) == 0, int'($urandom_range(0, 9)),
                              r_req, $urandom_range(0, 99) < ack_pct,
                              $urandom_range(0, 39) == 0, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall sequencer for the five-stage pipeline. Produces the 6-bit `control` hold vector consumed by the PC and by every inter-stage register; `control[3]` holds the EX/MEM register.
- Merges single-cycle hazard requests from IF and ID.
- Sequences multi-cycle EX operations with a countdown.
- Supervises MEM-stage bus handshakes with a timeout.

Parameters:
- MEM_TIMEOUT, 16: consecutive un-acked MEM wait cycles before timeout error (must be >= 2).
- CNT_W, 6: width of the EX cycle counter and the `ex_mc_cycles` input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_stall_req  in  1  fetch not ready this cycle.
- id_stall_req  in  1  decode hazard (load-use) this cycle.
- ex_mc_start  in  1  one-cycle pulse: EX begins a multi-cycle operation.
- ex_mc_cycles  in  CNT_W  total stall cycles N for that operation; sampled with `ex_mc_start`.
- mem_req  in  1  MEM stage has a bus access pending.
- mem_ack  in  1  bus acknowledges the access this cycle.
- flush  in  1  exception/redirect: abort all sequencing.
- control  out  6  hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved, always 0.
- ex_mc_done  out  1  registered pulse: EX result is valid; the EX/MEM register captures this cycle.
- mem_timeout  out  1  sticky error flag, cleared only by `flush` or `rst`.
- state_dbg  out  4  {ex_state, mem_state} for debug.

Behaviour:
- Reset (asynchronous):
  - ex_state = EX_IDLE, mem_state = MEM_IDLE, both counters = 0, `ex_mc_done` = 0, `mem_timeout` = 0.
  - `control` = 6'b000000 while `rst` is high.
- Control vector (combinational from state and requests):
  - Each source is assigned a stage index k: IF=1, ID=2, EX=3, MEM=4.
  - `control` = (1<<(k+1))-1 for the highest active k; 0 if no source is active.
  - Example: ID and MEM active together give 6'b011111.
  - Bit5 is never driven high.
- Flush:
  - Synchronous, highest priority below reset.
  - `control` = 0 in the flush cycle.
  - Next state: both FSMs IDLE, both counters 0, `mem_timeout` = 0, `ex_mc_done` = 0.
- EX FSM (states EX_IDLE, EX_BUSY, EX_DONE):
  - In IDLE or DONE, `ex_mc_start` with N=0: go to EX_DONE, no stall.
  - In IDLE or DONE, `ex_mc_start` with N>=1: EX stall active that cycle. If N=1, go to EX_DONE; else go to EX_BUSY with cnt = N-1.
  - EX_BUSY: EX stall active; cnt decrements each cycle; at cnt==1 go to EX_DONE.
  - Net effect: stall lasts exactly N consecutive cycles starting with the start cycle.
  - EX_DONE: `ex_mc_done` = 1 for one cycle, no EX stall; then EX_IDLE, unless a new start arrives in that cycle, which is handled as from IDLE.
  - `ex_mc_start` is ignored in EX_BUSY.
- MEM FSM (states MEM_IDLE, MEM_WAIT, MEM_ERR):
  - MEM stall = `mem_req` & ~`mem_ack` in IDLE or WAIT.
  - MEM_IDLE: on `mem_req` & ~`mem_ack`, go to WAIT with tcnt = 1.
  - MEM_WAIT, `mem_ack` = 1: go to IDLE; no stall that cycle.
  - MEM_WAIT, `mem_req` dropped: go to IDLE.
  - MEM_WAIT, still waiting with tcnt == MEM_TIMEOUT-1: go to ERR.
  - MEM_WAIT, otherwise: tcnt++.
  - Net effect: MEM stall lasts at most MEM_TIMEOUT cycles before the error.
  - MEM_ERR: `mem_timeout` = 1 and the MEM stall is held (bits 0..4) until `flush`. `mem_ack` is ignored.
- Concurrency:
  - The EX and MEM FSMs advance independently.
  - An EX countdown continues while MEM stalls; the higher mask dominates `control`.
  - An IF/ID request arriving during EX_BUSY has no additional effect.

Test Plan:
- Apply `rst` mid-EX_BUSY, asynchronously between clock edges -> `control` = 0 immediately; `ex_mc_done` = 0; after `rst` falls, states are IDLE.
- `id_stall_req` and `if_stall_req` high together for 1 cycle -> `control` = 6'b000111 that cycle, then 6'b000000.
- `ex_mc_start` with `ex_mc_cycles` = 4 -> `control` = 6'b001111 for exactly 4 cycles, `ex_mc_done` high on the 5th cycle with `control` = 0. Repeat with N=0 -> no stall, `ex_mc_done` on the next cycle. Repeat with N=1 -> 1 stalled cycle.
- `mem_req` held, `mem_ack` after 3 cycles -> `control` = 6'b011111 for 3 cycles, 0 in the ack cycle, `mem_timeout` stays 0.
- `mem_req` held, no ack, MEM_TIMEOUT = 16 -> 16 stalled cycles, then `mem_timeout` = 1 with the stall held; assert `flush` -> `control` = 0 that cycle, `mem_timeout` = 0 on the next cycle.
- EX start with N = 6 while a MEM wait is active for 2 cycles -> `control` = 6'b011111 for 2 cycles, then 6'b001111 for 4 cycles; `ex_mc_done` on cycle 7.
